answer_bank_drawer: RTL and testbench

//  Parametrised successor to the fixed 5-answer register bank, answer mux and box draw path of the game datapath.
//  - Captures up to NUM_SLOTS user colour entries; active length is set per round by `level`.
//  - Compares captured entries against the target sequence.
//  - Sweeps every answer box pixel-by-pixel as x/y/colour/plot for the VGA adapter.

---
 rtl/answer_bank_pkg.sv | 31 +++
 rtl/box_sweep_counter.sv | 89 ++++++++
 rtl/answer_bank_drawer.sv | 220 ++++++++++++++++++++++
 tb/tb_answer_bank_drawer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/answer_bank_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// answer_bank_pkg: shared FSM state, widths and level clamp helper.
// Rev 1.0
//------------------------------------------------------------------
package answer_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2,
    ST_DRAW    = 2'd3
  } state_e;

  localparam int CNT_W = 4;

  // Width of an index into n items, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_level(input logic [CNT_W-1:0] lvl,
                                                   input int num_slots);
    if (lvl == '0 || int'(lvl) > num_slots) begin
      return CNT_W'(num_slots);
    end
    return lvl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/box_sweep_counter.sv
`default_nettype none
//------------------------------------------------------------------
// box_sweep_counter: px/py/slot raster counters for the box sweep.
// Rev 1.0
//------------------------------------------------------------------
module box_sweep_counter
  import answer_bank_pkg::*;
#(
  parameter int NUM_SLOTS = 5,
  parameter int BOX_W     = 16,
  parameter int BOX_H     = 16,
  localparam int SLOT_W   = idx_w(NUM_SLOTS),
  localparam int PX_W     = idx_w(BOX_W),
  localparam int PY_W     = idx_w(BOX_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  len,
  output logic              busy,
  output logic              last,
  output logic [PX_W-1:0]   px,
  output logic [PY_W-1:0]   py,
  output logic [SLOT_W-1:0] slot
);

  localparam logic [PX_W-1:0] PX_MAX = PX_W'(BOX_W - 1);
  localparam logic [PY_W-1:0] PY_MAX = PY_W'(BOX_H - 1);

  logic              busy_q, busy_d;
  logic [PX_W-1:0]   px_q, px_d;
  logic [PY_W-1:0]   py_q, py_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  assign last = busy_q && (px_q == PX_MAX) && (py_q == PY_MAX) &&
                (CNT_W'(slot_q) == len - CNT_W'(1));

  always_comb begin
    busy_d = busy_q;
    px_d   = px_q;
    py_d   = py_q;
    slot_d = slot_q;
    if (abort || start) begin
      busy_d = start && !abort;
      px_d   = '0;
      py_d   = '0;
      slot_d = '0;
    end else if (busy_q) begin
      if (px_q == PX_MAX) begin
        px_d = '0;
        if (py_q == PY_MAX) begin
          py_d = '0;
          if (last) begin
            busy_d = 1'b0;
            slot_d = '0;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end else begin
          py_d = py_q + PY_W'(1);
        end
      end else begin
        px_d = px_q + PX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      px_q   <= '0;
      py_q   <= '0;
      slot_q <= '0;
    end else begin
      busy_q <= busy_d;
      px_q   <= px_d;
      py_q   <= py_d;
      slot_q <= slot_d;
    end
  end

  assign busy = busy_q;
  assign px   = px_q;
  assign py   = py_q;
  assign slot = slot_q;

endmodule
`default_nettype wire

// File: rtl/answer_bank_drawer.sv
`default_nettype none
//------------------------------------------------------------------
// answer_bank_drawer: answer capture, target compare, box redraw.
// Optional LIVE_CHECK_EN: stop on the first wrong entry. Rev 1.0
//------------------------------------------------------------------
module answer_bank_drawer
  import answer_bank_pkg::*;
#(
  parameter int NUM_SLOTS = 5,
  parameter int COL_W     = 3,
  parameter int BOX_W     = 16,
  parameter int BOX_H     = 16,
  parameter int X0        = 40,
  parameter int PITCH     = 24,
  parameter int Y0        = 97,
  parameter logic [COL_W-1:0] BG_COL = '0
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  input  logic                       start,
  input  logic [3:0]                 level,
  input  logic                       key_valid,
  input  logic [COL_W-1:0]           key_colour,
  input  logic [NUM_SLOTS*COL_W-1:0] target,
  input  logic                       draw_req,
  output logic [NUM_SLOTS*COL_W-1:0] all_ans,
  output logic [3:0]                 entry_count,
  output logic                       seq_full,
  output logic                       match,
  output logic                       mismatch,
  output logic [7:0]                 x,
  output logic [6:0]                 y,
  output logic [COL_W-1:0]           colour,
  output logic                       plot,
  output logic                       draw_busy,
  output logic                       draw_done
);

  localparam int SLOT_W = idx_w(NUM_SLOTS);
  localparam int PX_W   = idx_w(BOX_W);
  localparam int PY_W   = idx_w(BOX_H);

  state_e            state_q, state_d, ret_q, ret_d;
  logic [COL_W-1:0]  slot_q [NUM_SLOTS];
  logic [COL_W-1:0]  slot_d [NUM_SLOTS];
  logic [CNT_W-1:0]  count_q, count_d, len_q, len_d;
  logic              seq_full_q, seq_full_d, match_q, match_d;
  logic              mismatch_q, mismatch_d, live_bad_q, live_bad_d;
  logic              drain_q, drain_d, plot_q, plot_d, draw_done_q, draw_done_d;
  logic [7:0]        x_q, x_d;
  logic [6:0]        y_q, y_d;
  logic [COL_W-1:0]  colour_q, colour_d;

  logic [COL_W-1:0]  w_tgt [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_diff;
  logic [SLOT_W-1:0] w_cidx;
  logic              w_key_ok, w_key_bad;
  logic              w_sweep_start, w_sweep_abort, w_sweep_busy, w_sweep_last;
  logic [PX_W-1:0]   w_px;
  logic [PY_W-1:0]   w_py;
  logic [SLOT_W-1:0] w_slot;
  logic [7:0]        w_x;
  logic [6:0]        w_y;
  logic [COL_W-1:0]  w_pix_col;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    assign all_ans[i*COL_W +: COL_W] = slot_q[i];
    assign w_tgt[i]  = target[i*COL_W +: COL_W];
    assign w_diff[i] = (CNT_W'(i) < len_q) && (slot_q[i] != w_tgt[i]);
  end

  assign w_cidx   = count_q[SLOT_W-1:0];
  assign w_key_ok = key_valid && (count_q < len_q) &&
                    ((state_q == ST_CAPTURE) || (state_q == ST_DRAW && ret_q == ST_CAPTURE));

`ifdef LIVE_CHECK_EN
  assign w_key_bad = w_key_ok && (key_colour != w_tgt[w_cidx]);
`else
  assign w_key_bad = 1'b0;
`endif

  box_sweep_counter #(
    .NUM_SLOTS (NUM_SLOTS),
    .BOX_W     (BOX_W),
    .BOX_H     (BOX_H)
  ) u_sweep (
    .clk   (Clock),
    .rst_n (Resetn),
    .start (w_sweep_start),
    .abort (w_sweep_abort),
    .len   (len_q),
    .busy  (w_sweep_busy),
    .last  (w_sweep_last),
    .px    (w_px),
    .py    (w_py),
    .slot  (w_slot)
  );

  // Colour is read live so an entry captured mid-sweep shows on its remaining pixels.
  assign w_x       = 8'(X0 + PITCH * int'(w_slot) + int'(w_px));
  assign w_y       = 7'(Y0 + int'(w_py));
  assign w_pix_col = (CNT_W'(w_slot) < count_q) ? slot_q[w_slot] : BG_COL;

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    slot_d        = slot_q;
    count_d       = count_q;
    len_d         = len_q;
    seq_full_d    = seq_full_q;
    match_d       = match_q;
    mismatch_d    = mismatch_q;
    live_bad_d    = live_bad_q;
    drain_d       = 1'b0;
    plot_d        = 1'b0;
    draw_done_d   = 1'b0;
    x_d           = x_q;
    y_d           = y_q;
    colour_d      = colour_q;
    w_sweep_start = 1'b0;
    w_sweep_abort = 1'b0;

    if (start) begin
      state_d       = ST_CAPTURE;
      ret_d         = ST_CAPTURE;
      len_d         = clamp_level(level, NUM_SLOTS);
      count_d       = '0;
      for (int i = 0; i < NUM_SLOTS; i++) slot_d[i] = BG_COL;
      seq_full_d    = 1'b0;
      match_d       = 1'b0;
      mismatch_d    = 1'b0;
      live_bad_d    = 1'b0;
      w_sweep_abort = 1'b1;
    end else begin
      if (w_key_ok) begin
        slot_d[w_cidx] = key_colour;
        count_d        = count_q + CNT_W'(1);
        if (count_d == len_q || w_key_bad) begin
          seq_full_d = 1'b1;
          live_bad_d = w_key_bad;
          if (state_q == ST_DRAW) ret_d = ST_FULL;
          else state_d = ST_FULL;
        end
      end

      // Verdict is taken once, the cycle after seq_full rises, and then held.
      if (seq_full_q && !match_q && !mismatch_q) begin
        if (live_bad_q || (|w_diff)) mismatch_d = 1'b1;
        else match_d = 1'b1;
      end

      if (state_q == ST_DRAW) begin
        if (w_sweep_busy) begin
          plot_d   = 1'b1;
          x_d      = w_x;
          y_d      = w_y;
          colour_d = w_pix_col;
        end
        drain_d = w_sweep_last;
        if (drain_q) begin
          draw_done_d = 1'b1;
          state_d     = ret_d;
        end
      end else if (draw_req) begin
        ret_d         = state_d;
        state_d       = ST_DRAW;
        w_sweep_start = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= BG_COL;
      count_q     <= '0;
      len_q       <= CNT_W'(NUM_SLOTS);
      seq_full_q  <= 1'b0;
      match_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      live_bad_q  <= 1'b0;
      drain_q     <= 1'b0;
      plot_q      <= 1'b0;
      draw_done_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      slot_q      <= slot_d;
      count_q     <= count_d;
      len_q       <= len_d;
      seq_full_q  <= seq_full_d;
      match_q     <= match_d;
      mismatch_q  <= mismatch_d;
      live_bad_q  <= live_bad_d;
      drain_q     <= drain_d;
      plot_q      <= plot_d;
      draw_done_q <= draw_done_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
    end
  end

  assign entry_count = count_q;
  assign seq_full    = seq_full_q;
  assign match       = match_q;
  assign mismatch    = mismatch_q;
  assign x           = x_q;
  assign y           = y_q;
  assign colour      = colour_q;
  assign plot        = plot_q;
  assign draw_busy   = (state_q == ST_DRAW);
  assign draw_done   = draw_done_q;

endmodule
`default_nettype wire

// File: tb/tb_answer_bank_drawer.sv
`default_nettype none
//------------------------------------------------------------------
// tb_answer_bank_drawer: vector table plus hand sequences for draw/reset.
// Rev 1.0
//------------------------------------------------------------------
module tb_answer_bank_drawer;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  level = '0;
  logic        key_valid = 1'b0;
  logic [2:0]  key_colour = '0;
  logic [14:0] target = '0;
  logic        draw_req = 1'b0;
  logic [14:0] all_ans;
  logic [3:0]  entry_count;
  logic        seq_full, match, mismatch, plot, draw_busy, draw_done;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;

  int n_tests = 0;
  int n_fail  = 0;

  // Slot i sits at bits [3i +: 3]: T1 = {0,0,3,2,1}, T2 = {5,4,3,2,1}.
  localparam logic [14:0] T1 = 15'd209;
  localparam logic [14:0] T2 = 15'd22737;

  answer_bank_drawer dut (
    .Clock(Clock), .Resetn(Resetn), .start(start), .level(level),
    .key_valid(key_valid), .key_colour(key_colour), .target(target),
    .draw_req(draw_req), .all_ans(all_ans), .entry_count(entry_count),
    .seq_full(seq_full), .match(match), .mismatch(mismatch), .x(x), .y(y),
    .colour(colour), .plot(plot), .draw_busy(draw_busy), .draw_done(draw_done)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic [3:0]  lvl;
    logic        kv;
    logic [2:0]  kc;
    logic [14:0] tgt;
    logic [3:0]  e_cnt;
    logic        e_full, e_match, e_mm;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic [3:0] lvl, input logic kv,
                     input logic [2:0] kc, input logic [14:0] tgt, input logic [3:0] e_cnt,
                     input logic e_full, input logic e_match, input logic e_mm);
    vec_t v;
    v.st = st; v.lvl = lvl; v.kv = kv; v.kc = kc; v.tgt = tgt;
    v.e_cnt = e_cnt; v.e_full = e_full; v.e_match = e_match; v.e_mm = e_mm;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_start(input logic [3:0] lvl);
    start = 1'b1; level = lvl; tick(); start = 1'b0;
  endtask

  task automatic do_key(input logic [2:0] c);
    key_valid = 1'b1; key_colour = c; tick(); key_valid = 1'b0;
  endtask

  function automatic logic [42:0] all_outs();
    return {all_ans, entry_count, seq_full, match, mismatch, x, y, colour,
            plot, draw_busy, draw_done};
  endfunction

  initial begin
    int plots, pix_err, bg_err, done_cnt, last_plot_c, done_c, late_plot;
    logic [7:0] fx, lx;
    logic [6:0] fy, ly;

    // Level 3 capture/match, 4th key ignored.
    add(1, 3, 0, 0, T1, 0, 0, 0, 0);
    add(0, 0, 1, 1, T1, 1, 0, 0, 0);
    add(0, 0, 1, 2, T1, 2, 0, 0, 0);
    add(0, 0, 1, 3, T1, 3, 1, 0, 0);
    add(0, 0, 0, 0, T1, 3, 1, 1, 0);
    add(0, 0, 1, 4, T1, 3, 1, 1, 0);
    // Level 5 with a wrong last key.
    add(1, 5, 0, 0, T2, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) add(0, 0, 1, 3'(k), T2, 4'(k), 0, 0, 0);
    add(0, 0, 1, 6, T2, 5, 1, 0, 0);
    add(0, 0, 0, 0, T2, 5, 1, 0, 1);
    add(0, 0, 0, 0, T2, 5, 1, 0, 1);
    // Level 0 and level 9 both clamp to 5.
    for (int l = 0; l < 2; l++) begin
      add(1, (l == 0) ? 4'd0 : 4'd9, 0, 0, T2, 0, 0, 0, 0);
      for (int k = 1; k <= 4; k++) add(0, 0, 1, 3'(k), T2, 4'(k), 0, 0, 0);
      add(0, 0, 1, 5, T2, 5, 1, 0, 0);
      add(0, 0, 0, 0, T2, 5, 1, 1, 0);
    end
    // start beats key_valid in the same cycle.
    add(1, 3, 1, 5, T2, 0, 0, 0, 0);
    add(0, 0, 1, 1, T2, 1, 0, 0, 0);

    // Reset state.
    #3;
    check("reset_outs", 64'(all_outs()), 64'd0);
    tick();
    Resetn = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].st; level = vecs[i].lvl; key_valid = vecs[i].kv;
      key_colour = vecs[i].kc; target = vecs[i].tgt;
      tick();
      check($sformatf("vec%0d", i), 64'({entry_count, seq_full, match, mismatch}),
            64'({vecs[i].e_cnt, vecs[i].e_full, vecs[i].e_match, vecs[i].e_mm}));
    end
    start = 1'b0; key_valid = 1'b0;

    // Asynchronous reset mid-run.
    #2 Resetn = 1'b0;
    #1 check("async_reset_outs", 64'(all_outs()), 64'd0);
    #2 Resetn = 1'b1;
    tick();
    do_key(3'd4);
    check("idle_ignores_key", 64'(entry_count), 64'd0);

    // Full redraw after two of five entries.
    target = T2;
    do_start(4'd5);
    do_key(3'd1);
    do_key(3'd2);
    draw_req = 1'b1; tick(); draw_req = 1'b0;
    check("draw_busy_on", 64'(draw_busy), 64'd1);
    plots = 0; pix_err = 0; bg_err = 0; done_cnt = 0; late_plot = 0;
    last_plot_c = -1; done_c = -1;
    fx = '0; fy = '0; lx = '0; ly = '0;
    for (int c = 0; c < 1300; c++) begin
      tick();
      if (plot) begin
        int s, r, ex, ey, ec;
        s = plots / 256; r = plots % 256;
        ex = 40 + 24 * s + (r % 16); ey = 97 + (r / 16);
        ec = (s == 0) ? 1 : (s == 1) ? 2 : 0;
        if (plots == 0) begin fx = x; fy = y; end
        lx = x; ly = y;
        if (x !== 8'(ex) || y !== 7'(ey) || colour !== 3'(ec)) pix_err++;
        if (s >= 2 && colour !== 3'd0) bg_err++;
        if (done_cnt != 0) late_plot++;
        plots++;
        last_plot_c = c;
      end
      if (draw_done) begin
        done_cnt++;
        done_c = c;
      end
    end
    check("plot_cycles", 64'(plots), 64'd1280);
    check("pixel_errors", 64'(pix_err), 64'd0);
    check("bg_slot_errors", 64'(bg_err), 64'd0);
    check("first_pixel", 64'({fx, fy}), 64'({8'd40, 7'd97}));
    check("last_pixel", 64'({lx, ly}), 64'({8'd151, 7'd112}));
    check("draw_done_count", 64'(done_cnt), 64'd1);
    check("draw_done_timing", 64'(done_c - last_plot_c), 64'd1);
    check("plot_after_done", 64'(late_plot), 64'd0);
    check("draw_busy_off", 64'(draw_busy), 64'd0);
    do_key(3'd3);
    check("back_in_capture", 64'(entry_count), 64'd3);

    // start aborts a sweep in progress.
    draw_req = 1'b1; tick(); draw_req = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    check("mid_draw_plot", 64'(plot), 64'd1);
    do_start(4'd5);
    check("abort_plot_drop", 64'({plot, draw_busy, entry_count}), 64'd0);
    done_cnt = 0; plots = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (draw_done) done_cnt++;
      if (plot) plots++;
    end
    check("abort_no_done", 64'({done_cnt, plots}), 64'd0);

    // Second key wrong.
    target = T2;
    do_start(4'd5);
    do_key(3'd1);
    do_key(3'd7);
`ifdef LIVE_CHECK_EN
    check("live_full", 64'({seq_full, mismatch}), 64'({1'b1, 1'b0}));
    tick();
    check("live_mismatch", 64'({seq_full, match, mismatch}), 64'({1'b1, 1'b0, 1'b1}));
    do_key(3'd3);
    check("live_key_ignored", 64'(entry_count), 64'd2);
`else
    check("late_full", 64'({seq_full, mismatch}), 64'd0);
    tick();
    check("late_no_mismatch", 64'({seq_full, match, mismatch}), 64'd0);
    do_key(3'd3);
    do_key(3'd4);
    do_key(3'd5);
    check("late_full_set", 64'({entry_count, seq_full, mismatch}), 64'({4'd5, 1'b1, 1'b0}));
    tick();
    check("late_mismatch", 64'({match, mismatch}), 64'({1'b0, 1'b1}));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
